// File: rtl/game_stats.sv
// Score/fruit/lives register file, round countdown timer and a serial
// double-dabble converter that presents the score as four BCD digits.
module game_stats #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter logic [31:0] ROUND_SECS    = 32'd120,
    parameter logic [9:0]  DOT_POINTS    = 10'd10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        restart,
    input  logic        pause,
    input  logic        dot_eaten,
    input  logic        Load_S,
    input  logic [9:0]  score_to_reg,
    input  logic        Load_F,
    input  logic [3:0]  fruits_to_reg,
    input  logic        Load_L,
    input  logic [7:0]  lives_to_reg,
    output logic [9:0]  score,
    output logic [3:0]  fruits,
    output logic [7:0]  lives,
    output logic [31:0] counter,
    output logic [15:0] score_bcd,
    output logic        bcd_valid
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_state_t;

    bcd_state_t  bcd_state, bcd_state_nxt;
    logic [31:0] presc;
    logic [9:0]  score_base, score_nxt;
    logic [10:0] score_sum;
    logic        score_changed;
    logic        pending;
    logic [9:0]  bin;
    logic [15:0] work, work_adj;
    logic [3:0]  shift_cnt;

    // Score datapath: the sum is one bit wider so overflow saturates instead of wrapping.
    always_comb begin
        score_base    = Load_S ? score_to_reg : score;
        score_sum     = {1'b0, score_base} + {1'b0, DOT_POINTS};
        score_nxt     = score_base;
        if (dot_eaten)
            score_nxt = score_sum[10] ? 10'h3FF : score_sum[9:0];
        score_changed = (score_nxt != score);
    end

    // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < 4; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_state_nxt = bcd_state;
        case (bcd_state)
            IDLE:    if (score_changed) bcd_state_nxt = LOAD;
            LOAD:    bcd_state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 4'd1) bcd_state_nxt = DONE;
            DONE:    bcd_state_nxt = (pending || score_changed) ? LOAD : IDLE;
            default: bcd_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset || restart) begin
            score     <= '0;
            fruits    <= '0;
            lives     <= '0;
            counter   <= ROUND_SECS;
            presc     <= '0;
            bcd_state <= IDLE;
            score_bcd <= '0;
            bcd_valid <= 1'b1;
            pending   <= 1'b0;
            bin       <= '0;
            work      <= '0;
            shift_cnt <= '0;
        end else begin
            score     <= score_nxt;
            bcd_state <= bcd_state_nxt;
            if (Load_F) fruits <= fruits_to_reg;
            if (Load_L) lives  <= lives_to_reg;

            // Once the countdown hits zero both counter and prescaler park.
            if (!pause && counter != 32'd0) begin
                if (presc == 32'(TICKS_PER_SEC - 1)) begin
                    presc   <= '0;
                    counter <= counter - 32'd1;
                end else begin
                    presc <= presc + 32'd1;
                end
            end

            case (bcd_state)
                IDLE: begin
                    if (score_changed) bcd_valid <= 1'b0;
                end
                LOAD: begin
                    bin       <= score;
                    work      <= '0;
                    shift_cnt <= 4'd10;
                    pending   <= score_changed;
                end
                SHIFT: begin
                    {work, bin} <= {work_adj[14:0], bin, 1'b0};
                    shift_cnt   <= shift_cnt - 4'd1;
                    if (score_changed) pending <= 1'b1;
                end
                DONE: begin
                    // A stale result is discarded so score_bcd never shows an old score as valid.
                    if (!(pending || score_changed)) begin
                        score_bcd <= work;
                        bcd_valid <= 1'b1;
                    end
                    pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
